// File: rtl/traffic_light_ctrl.sv
// Two-way (main/side) intersection controller with a BCD seconds countdown,
// a pedestrian shortcut on main green, and a night flashing-yellow mode.
module traffic_light_ctrl #(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned T_GREEN  = 30,
  parameter int unsigned T_YELLOW = 3,
  parameter int unsigned T_ALLRED = 2,
  parameter int unsigned T_PED    = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ped_req,
  input  logic       night,
  output logic [2:0] main_rgy,
  output logic [2:0] side_rgy,
  output logic [3:0] cnt_tens,
  output logic [3:0] cnt_units,
  output logic       tens_off,
  output logic       units_off
);

  typedef enum logic [2:0] {
    MAIN_GREEN, MAIN_YELLOW, ALL_RED_1, SIDE_GREEN, SIDE_YELLOW, ALL_RED_2, FLASH
  } state_t;

  localparam int unsigned PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  localparam logic [7:0] BCD_GREEN  = {4'(T_GREEN / 10),  4'(T_GREEN % 10)};
  localparam logic [7:0] BCD_YELLOW = {4'(T_YELLOW / 10), 4'(T_YELLOW % 10)};
  localparam logic [7:0] BCD_ALLRED = {4'(T_ALLRED / 10), 4'(T_ALLRED % 10)};
  localparam logic [7:0] BCD_PED    = {4'(T_PED / 10),    4'(T_PED % 10)};

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  state_t        state, state_next;
  logic [7:0]    cnt, cnt_next;
  logic [PW-1:0] presc, presc_next;
  logic          ped_pending, pend_next;
  logic          flash, flash_next;
  logic          ped_s1, ped_s2, ped_s3;
  logic          night_s1, night_s2;
  logic          tick, ped_rise;

  logic [2:0]    main_next, side_next;
  logic          tens_off_next, units_off_next;

  function automatic state_t phase_after(input state_t s);
    case (s)
      MAIN_GREEN:  return MAIN_YELLOW;
      MAIN_YELLOW: return ALL_RED_1;
      ALL_RED_1:   return SIDE_GREEN;
      SIDE_GREEN:  return SIDE_YELLOW;
      SIDE_YELLOW: return ALL_RED_2;
      default:     return MAIN_GREEN;
    endcase
  endfunction

  function automatic logic [7:0] phase_len(input state_t s);
    case (s)
      MAIN_GREEN, SIDE_GREEN:   return BCD_GREEN;
      MAIN_YELLOW, SIDE_YELLOW: return BCD_YELLOW;
      FLASH:                    return 8'h00;
      default:                  return BCD_ALLRED;
    endcase
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                return {v[7:4], v[3:0] - 4'd1};
  endfunction

  assign tick     = (presc == PRESC_MAX);
  assign ped_rise = ped_s2 & ~ped_s3;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    flash_next = flash;
    pend_next  = ped_pending | ped_rise;
    presc_next = tick ? '0 : presc + 1'b1;

    if (state == FLASH) begin
      pend_next = 1'b0;
      if (!night_s2) begin
        state_next = ALL_RED_2;
        cnt_next   = BCD_ALLRED;
        flash_next = 1'b0;
      end else if (tick) begin
        flash_next = ~flash;
      end
    end else if (night_s2) begin
      state_next = FLASH;
      cnt_next   = '0;
      flash_next = 1'b0;
      presc_next = '0;
      pend_next  = 1'b0;
    end else if (tick) begin
      // A tick always wins; a pending shortcut is re-evaluated the next cycle.
      if (cnt == 8'h01) begin
        state_next = phase_after(state);
        cnt_next   = phase_len(state_next);
        if (state_next == SIDE_GREEN) pend_next = 1'b0;
      end else begin
        cnt_next = bcd_dec(cnt);
      end
    end else if (state == MAIN_GREEN && ped_pending && cnt > BCD_PED) begin
      cnt_next  = BCD_PED;
      pend_next = ped_rise;
    end
  end

  always_comb begin
    main_next      = LAMP_R;
    side_next      = LAMP_R;
    tens_off_next  = (cnt_next[7:4] == 4'd0);
    units_off_next = 1'b0;
    case (state_next)
      MAIN_GREEN:  main_next = LAMP_G;
      MAIN_YELLOW: main_next = LAMP_Y;
      SIDE_GREEN:  side_next = LAMP_G;
      SIDE_YELLOW: side_next = LAMP_Y;
      FLASH: begin
        main_next      = {1'b0, flash_next, 1'b0};
        side_next      = {1'b0, flash_next, 1'b0};
        tens_off_next  = 1'b1;
        units_off_next = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_s1   <= 1'b0;
      ped_s2   <= 1'b0;
      ped_s3   <= 1'b0;
      night_s1 <= 1'b0;
      night_s2 <= 1'b0;
    end else begin
      ped_s1   <= ped_req;
      ped_s2   <= ped_s1;
      ped_s3   <= ped_s2;
      night_s1 <= night;
      night_s2 <= night_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ALL_RED_2;
      cnt         <= BCD_ALLRED;
      presc       <= '0;
      ped_pending <= 1'b0;
      flash       <= 1'b0;
      main_rgy    <= LAMP_R;
      side_rgy    <= LAMP_R;
      cnt_tens    <= BCD_ALLRED[7:4];
      cnt_units   <= BCD_ALLRED[3:0];
      tens_off    <= (BCD_ALLRED[7:4] == 4'd0);
      units_off   <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      presc       <= presc_next;
      ped_pending <= pend_next;
      flash       <= flash_next;
      main_rgy    <= main_next;
      side_rgy    <= side_next;
      cnt_tens    <= cnt_next[7:4];
      cnt_units   <= cnt_next[3:0];
      tens_off    <= tens_off_next;
      units_off   <= units_off_next;
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench: expected display steps are queued ahead of the DUT and
// popped each time the registered outputs change.
module tb_traffic_light_ctrl;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       rst_n, ped_req, night;
  logic [2:0] main_rgy, side_rgy;
  logic [3:0] cnt_tens, cnt_units;
  logic       tens_off, units_off;

  traffic_light_ctrl #(
    .CLK_HZ(4), .T_GREEN(12), .T_YELLOW(3), .T_ALLRED(2), .T_PED(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ped_req(ped_req), .night(night),
    .main_rgy(main_rgy), .side_rgy(side_rgy),
    .cnt_tens(cnt_tens), .cnt_units(cnt_units),
    .tens_off(tens_off), .units_off(units_off)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] vec;
    int          dur;
    string       tag;
  } item_t;

  item_t       q[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 0;
  bit          inv_en = 0;
  bit          have_prev = 0;
  logic [15:0] prev;
  int          hold = 0;
  int          cur_dur = 0;

  function automatic logic [15:0] obs_vec();
    return {main_rgy, side_rgy, cnt_tens, cnt_units, tens_off, units_off};
  endfunction

  function automatic logic [15:0] mk(input logic [2:0] m, input logic [2:0] s, input int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {m, s, t, u, (t == 4'd0), 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk_int(input string tag, input int o, input int e);
    checks++;
    assert (o == e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic push(input string name, input logic [2:0] m, input logic [2:0] s,
                      input int v, input int dur);
    item_t it;
    it.vec = mk(m, s, v);
    it.dur = dur;
    it.tag = $sformatf("%s_%0d", name, v);
    q.push_back(it);
  endtask

  task automatic run(input string name, input logic [2:0] m, input logic [2:0] s,
                     input int from, input int to);
    for (int v = from; v >= to; v--) push(name, m, s, v, 4);
  endtask

  task automatic push_flash(input logic f, input int dur);
    item_t it;
    it.vec = {1'b0, f, 1'b0, 1'b0, f, 1'b0, 8'h00, 2'b11};
    it.dur = dur;
    it.tag = $sformatf("flash_%0d", f);
    q.push_back(it);
  endtask

  task automatic cyc();
    logic [15:0] o;
    item_t it;
    @(negedge clk);
    o = obs_vec();
    if (!mon_en) begin
      have_prev = 0;
    end else if (!have_prev || o !== prev) begin
      if (have_prev && cur_dur != 0) chk_int("hold_clks", hold, cur_dur);
      checks++;
      assert (q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_change observed=%h expected=none", o);
      end
      if (q.size() != 0) begin
        it = q.pop_front();
        chk(it.tag, o, it.vec);
        cur_dur = it.dur;
      end
      prev = o;
      have_prev = 1;
      hold = 1;
    end else begin
      hold++;
    end
    if (inv_en) begin
      checks++;
      assert (units_off || !((|main_rgy[1:0]) && (|side_rgy[1:0]))) else begin
        errors++;
        $error("FAIL conflict observed=%b/%b expected=one_road_red", main_rgy, side_rgy);
      end
      checks++;
      assert (cnt_tens <= 4'd9 && cnt_units <= 4'd9) else begin
        errors++;
        $error("FAIL bcd_range observed=%h%h expected=<=99", cnt_tens, cnt_units);
      end
    end
  endtask

  task automatic wait_empty(input string tag, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (q.size() == 0) break;
      cyc();
    end
    chk_int({tag, "_drain_left"}, q.size(), 0);
  endtask

  task automatic full_cycle_after_main();
    run("MY", Y, R, 3, 1);
    run("AR1", R, R, 2, 1);
    run("SG", R, G, 12, 1);
    run("SY", R, Y, 3, 1);
    run("AR2", R, R, 2, 1);
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; ped_req = 1'b0; night = 1'b0;
    repeat (3) cyc();
    chk("reset_state", obs_vec(), mk(R, R, 2));

    // Normal sequence from reset release, including 10->09 tens blanking.
    rst_n = 1'b1;
    mon_en = 1;
    push("AR2", R, R, 2, 0);
    push("AR2", R, R, 1, 4);
    run("MG", G, R, 12, 1);
    full_cycle_after_main();
    push("MG", G, R, 12, 4);
    push("MG", G, R, 11, 0);
    wait_empty("seq1", 400);

    // Pedestrian shortcut from count 11.
    mon_en = 0;
    ped_req = 1'b1;
    cyc();
    ped_req = 1'b0;
    found = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (obs_vec() === mk(G, R, 5)) begin
        found = 1;
        break;
      end
    end
    chk_int("ped_shortcut_seen", int'(found), 1);
    mon_en = 1;
    push("MGp", G, R, 5, 0);
    run("MGp", G, R, 4, 3);
    wait_empty("ped1", 60);

    // Request at count 03: no effect now, and must not survive into the next main green.
    ped_req = 1'b1;
    cyc();
    ped_req = 1'b0;
    run("MGp", G, R, 2, 1);
    full_cycle_after_main();
    run("MG2", G, R, 12, 1);
    run("MY", Y, R, 3, 1);
    run("AR1", R, R, 2, 1);
    run("SG", R, G, 12, 10);
    push("SG", R, G, 9, 0);
    wait_empty("ped2", 600);

    // Night flash mode entered mid side green.
    night = 1'b1;
    push_flash(1'b0, 4);
    push_flash(1'b1, 4);
    push_flash(1'b0, 4);
    push_flash(1'b1, 0);
    wait_empty("night_on", 60);
    night = 1'b0;
    push("AR2n", R, R, 2, 0);
    push("AR2n", R, R, 1, 4);
    run("MGn", G, R, 12, 1);
    push("MYn", Y, R, 3, 4);
    push("MYn", Y, R, 2, 0);
    wait_empty("night_off", 120);

    // Asynchronous reset mid main yellow.
    #1 rst_n = 1'b0;
    #1 chk("reset_async", obs_vec(), mk(R, R, 2));
    mon_en = 0;
    repeat (2) cyc();
    chk("reset_held", obs_vec(), mk(R, R, 2));
    rst_n = 1'b1;
    mon_en = 1;
    push("AR2r", R, R, 2, 0);
    push("AR2r", R, R, 1, 4);
    run("MGr", G, R, 12, 1);
    push("MYr", Y, R, 3, 0);
    wait_empty("restart", 120);

    // Random pedestrian/night activity with safety invariants every cycle.
    mon_en = 0;
    inv_en = 1;
    for (int t = 0; t < 10000; t++) begin
      ped_req = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) night = ~night;
      repeat (4) cyc();
    end
    ped_req = 1'b0;
    night = 1'b0;
    repeat (8) cyc();
    chk_int("night_exit_units_off", int'(units_off), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
